cbus_arbiter: RTL and testbench

Arbitrates the single off-chip `cbus` between NUM_PORTS cache-side requesters (port 0 = ICache, port 1 = DCache by default). It sits between the cache refill/write-through paths and the memory bus. A port is granted round-robin and locked until the final beat handshake (`ready && last`). A beat counter flags bursts whose length disagrees with the granted request's `len`.

---
 rtl/cbus_arbiter_if.sv | 43 ++++
 rtl/cbus_arbiter.sv | 117 +++++++++++
 tb/tb_cbus_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_if.sv
// cbus request/response types and the bundle that carries the cache-side and
// memory-side cbus channels into the arbiter.
package cbus_pkg;

  // len encodes beats-1: MLEN1 is a single beat, MLEN4 is four beats.
  localparam logic [3:0] MLEN1 = 4'd0;
  localparam logic [3:0] MLEN2 = 4'd1;
  localparam logic [3:0] MLEN4 = 4'd3;
  localparam logic [3:0] MLEN8 = 4'd7;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
  parameter int unsigned NUM_PORTS = 2
);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_PORTS];
  cbus_resp_t iresps [NUM_PORTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  // slave: the arbiter; master: caches plus memory bus around it.
  modport slave  (input ireqs, input oresp, output iresps, output oreq);
  modport master (output ireqs, output oresp, input iresps, input oreq);

endinterface

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one off-chip cbus between NUM_PORTS cache ports; a granted
// port stays locked until its last-beat handshake, and burst length mismatches are flagged.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CNT_BITS  = 4,
  localparam int unsigned SelW     = $clog2(NUM_PORTS)
) (
  input  logic            clk,
  input  logic            reset,
  cbus_arbiter_if.slave   bus,
  output logic [SelW-1:0] grant,
  output logic            busy,
  output logic            len_err
);

  localparam int unsigned CntW = CNT_BITS + 1;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [SelW-1:0]     prio_q, prio_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                err_seen_q, err_seen_d;
  logic                len_err_d;

  logic [SelW-1:0]     idx;
  logic [SelW-1:0]     pick;
  logic                pick_vld;
  cbus_req_t           req_sel;
  logic [CntW-1:0]     cnt_ext, len_ext;

  assign req_sel = bus.ireqs[sel_q];
  assign cnt_ext = {1'b0, cnt_q};
  assign len_ext = CntW'(req_sel.len);

  // First valid port at or after prio, wrapping around.
  always_comb begin
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = SelW'((32'(prio_q) + k) % NUM_PORTS);
      if (!pick_vld && bus.ireqs[idx].valid) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    err_seen_d = err_seen_q;
    len_err_d  = 1'b0;
    bus.oreq   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      bus.iresps[i] = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d    = StBusy;
          sel_d      = pick;
          cnt_d      = '0;
          err_seen_d = 1'b0;
        end
      end
      StBusy: begin
        bus.oreq          = req_sel;
        bus.iresps[sel_q] = bus.oresp;
        if (bus.oresp.ready) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
          if (bus.oresp.last) begin
            state_d   = StIdle;
            prio_d    = (sel_q == SelW'(NUM_PORTS - 1)) ? '0 : sel_q + SelW'(1);
            // An overrun already reported this burst; do not flag it twice.
            len_err_d = (cnt_ext != len_ext) && !err_seen_q;
          end else if (cnt_ext == len_ext) begin
            len_err_d  = !err_seen_q;
            err_seen_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      prio_q     <= '0;
      cnt_q      <= '0;
      err_seen_q <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      err_seen_q <= err_seen_d;
      len_err    <= len_err_d;
    end
  end

  assign busy  = (state_q == StBusy);
  assign grant = busy ? sel_q : '0;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: grants and beats are queued as expectations when
// driven and checked when the arbiter presents them.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int unsigned NP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] grant;
  logic       busy;
  logic       len_err;

  int errors = 0;
  int checks = 0;

  cbus_req_t   exp_req_q[$];
  int unsigned exp_grant_q[$];
  cbus_resp_t  exp_beat_q[$];

  cbus_arbiter_if #(.NUM_PORTS(NP)) bus ();

  cbus_arbiter #(.NUM_PORTS(NP), .CNT_BITS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .grant   (grant),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cbus_req_t mk_req(input logic w, input logic [31:0] addr,
                                       input logic [3:0] strobe, input logic [31:0] data,
                                       input logic [3:0] len);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = w;
    r.size     = 3'd2;
    r.addr     = addr;
    r.strobe   = strobe;
    r.data     = data;
    r.len      = len;
    return r;
  endfunction

  task automatic request(input int unsigned p, input cbus_req_t r);
    bus.ireqs[p] = r;
    exp_req_q.push_back(r);
    exp_grant_q.push_back(p);
  endtask

  // Waits (bounded) for busy, then checks latency, forwarded request and grant.
  task automatic expect_grant(input string tag);
    int unsigned waited = 0;
    cbus_req_t   er;
    int unsigned eg;
    do begin
      next_cycle();
      settle();
      waited++;
    end while (!busy && waited < 8);
    check({tag, "_latency"}, 128'(waited), 128'(1));
    er = exp_req_q.pop_front();
    eg = exp_grant_q.pop_front();
    check({tag, "_oreq"}, 128'(bus.oreq), 128'(er));
    check({tag, "_grant"}, 128'(grant), 128'(eg));
  endtask

  // n ready beats; last on beat last_at (0: never); optional request injected at inj_at.
  task automatic beats(input string tag, input int unsigned p, input int unsigned n,
                       input int unsigned last_at, input int unsigned inj_at,
                       input int unsigned inj_p, input cbus_req_t inj);
    cbus_resp_t  r, e;
    int unsigned len1;
    logic        exp_err;
    len1 = int'(bus.ireqs[p].len) + 1;
    for (int unsigned b = 1; b <= n; b++) begin
      next_cycle();
      if (b == inj_at) request(inj_p, inj);
      r.ready = 1'b1;
      r.last  = (b == last_at);
      r.data  = $urandom();
      bus.oresp = r;
      exp_beat_q.push_back(r);
      settle();
      e = exp_beat_q.pop_front();
      check($sformatf("%s_beat%0d", tag, b), 128'(bus.iresps[p]), 128'(e));
      for (int unsigned q = 0; q < NP; q++) begin
        if (q != p) check($sformatf("%s_idle_resp%0d_b%0d", tag, q, b),
                          128'(bus.iresps[q]), 128'(0));
      end
      check($sformatf("%s_grant_b%0d", tag, b), 128'(grant), 128'(p));
      exp_err = (b >= 2) && (b - 1 == len1);
      check($sformatf("%s_len_err_b%0d", tag, b), 128'(len_err), 128'(exp_err));
    end
  endtask

  // Cycle after the last handshake: arbiter idle, len_err as expected.
  task automatic finish(input string tag, input int unsigned p, input logic exp_err);
    next_cycle();
    bus.oresp          = '0;
    bus.ireqs[p].valid = 1'b0;
    settle();
    check({tag, "_busy_drop"}, 128'(busy), 128'(0));
    check({tag, "_len_err"}, 128'(len_err), 128'(exp_err));
  endtask

  initial begin
    reset     = 1'b1;
    bus.oresp = '0;
    for (int unsigned p = 0; p < NP; p++) bus.ireqs[p] = '0;
    next_cycle();
    next_cycle();
    settle();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_grant", 128'(grant), 128'(0));
    check("rst_len_err", 128'(len_err), 128'(0));
    check("rst_oreq", 128'(bus.oreq), 128'(0));
    check("rst_iresp0", 128'(bus.iresps[0]), 128'(0));
    check("rst_iresp1", 128'(bus.iresps[1]), 128'(0));

    // Single 4-beat read on port 1.
    next_cycle();
    reset = 1'b0;
    request(1, mk_req(1'b0, 32'h0000_1000, 4'hf, 32'h0, MLEN4));
    settle();
    check("t1_no_early_valid", 128'(bus.oreq.valid), 128'(0));
    expect_grant("t1");
    beats("t1", 1, 4, 4, 0, 0, '0);
    finish("t1", 1, 1'b0);

    // Both ports valid: 0 first, then 1 (with port 0 re-requesting mid-burst), then 0.
    next_cycle();
    request(0, mk_req(1'b0, 32'h0000_2000, 4'hf, 32'h0, MLEN2));
    request(1, mk_req(1'b0, 32'h0000_3000, 4'hf, 32'h0, MLEN4));
    settle();
    expect_grant("t2a");
    beats("t2a", 0, 2, 2, 0, 0, '0);
    finish("t2a", 0, 1'b0);
    expect_grant("t2b");
    beats("t2b", 1, 4, 4, 2, 0, mk_req(1'b0, 32'h0000_4000, 4'hf, 32'h0, MLEN1));
    finish("t2b", 1, 1'b0);
    expect_grant("t2c");
    beats("t2c", 0, 1, 1, 0, 0, '0);
    finish("t2c", 0, 1'b0);

    // Single-beat write passes through bit-identical.
    next_cycle();
    request(1, mk_req(1'b1, 32'h0000_5004, 4'b0011, 32'hdead_beef, MLEN1));
    settle();
    expect_grant("t4");
    beats("t4", 1, 1, 1, 0, 0, '0);
    finish("t4", 1, 1'b0);

    // Short burst: last on beat 2 of a 4-beat request.
    next_cycle();
    request(0, mk_req(1'b0, 32'h0000_6000, 4'hf, 32'h0, MLEN4));
    settle();
    expect_grant("t5");
    beats("t5", 0, 2, 2, 0, 0, '0);
    finish("t5", 0, 1'b1);
    next_cycle();
    settle();
    check("t5_pulse_end", 128'(len_err), 128'(0));

    // Overrun: 3 beats on a 2-beat request flags once, at the third beat.
    next_cycle();
    request(1, mk_req(1'b0, 32'h0000_7000, 4'hf, 32'h0, MLEN2));
    settle();
    expect_grant("t6");
    beats("t6", 1, 3, 3, 0, 0, '0);
    finish("t6", 1, 1'b0);

    // Reset in the middle of a burst, then a fresh grant.
    next_cycle();
    request(0, mk_req(1'b0, 32'h0000_8000, 4'hf, 32'h0, MLEN4));
    settle();
    expect_grant("t7");
    beats("t7", 0, 2, 0, 0, 0, '0);
    next_cycle();
    bus.oresp          = '0;
    bus.ireqs[0].valid = 1'b0;
    reset              = 1'b1;
    settle();
    check("t7_valid_follows", 128'(bus.oreq.valid), 128'(0));
    check("t7_still_locked", 128'(busy), 128'(1));
    next_cycle();
    reset = 1'b0;
    bus.ireqs[0] = '0;
    request(1, mk_req(1'b0, 32'h0000_9000, 4'hf, 32'h0, MLEN1));
    settle();
    check("t7_rst_oreq", 128'(bus.oreq), 128'(0));
    check("t7_rst_busy", 128'(busy), 128'(0));
    check("t7_rst_grant", 128'(grant), 128'(0));
    expect_grant("t7r");
    beats("t7r", 1, 1, 1, 0, 0, '0);
    finish("t7r", 1, 1'b0);

    check("sb_req_drained", 128'(exp_req_q.size()), 128'(0));
    check("sb_beat_drained", 128'(exp_beat_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
